seq_div_16: RTL and testbench
=============================

# seq_div_16

Sequential 16-bit signed integer divider for the CPU datapath; it is the inverse companion of the 16-bit signed multiplier unit. It accepts a dividend/divisor pair under a start/busy/done handshake and runs one restoring-division step per clock on operand magnitudes. A final cycle applies sign correction. Results match truncating (round-toward-zero) semantics: quotient `A / B`, remainder `A % B`, both wrapped to 16 bits.

## Interface
- `WIDTH`, default 16: operand and result width. Only 16 is verified.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  16 signed: dividend; sampled on the accepting edge only.
- `b`  in  16 signed: divisor; sampled on the accepting edge only.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when `quotient` and `remainder` are updated.
- `quotient`  out  16 signed: registered quotient; holds until the next completion.
- `remainder`  out  16 signed: registered remainder; holds until the next completion.
- `div_zero`  out  1: present only with `SEQ_DIV_ZERO_ERR_EN` (see Configuration).

## Operation
- States are IDLE, CALC and FIX.
- **IDLE, `start`=1:**
  - latch `|a|` and `|b|` as 16-bit unsigned values (`|-32768|` = 32768);
  - latch `neg_q = a[15]^b[15]` and `neg_r = a[15]`;
  - clear the 17-bit partial remainder and set the step counter to 15;
  - go to CALC.
- **CALC:** perform one restoring step per cycle:
  - shift {rem, dividend} left by 1 and form `trial = rem - |b|`;
  - if `trial >= 0`, set `rem = trial` and set the quotient bit to 1; otherwise the quotient bit is 0;
  - after the step with counter = 0, go to FIX; otherwise decrement the counter.
- **FIX:**
  - `quotient = neg_q ? -q_mag : q_mag` and `remainder = neg_r ? -r_mag : r_mag`, both truncated to 16 bits;
  - assert `done` and return to IDLE.
- Arithmetic rules:
  - remainder sign follows the dividend, and `|remainder| < |b|`;
  - `-32768 / -1` gives quotient -32768 (wrap) and remainder 0.
- Divide by zero (`b`=0) needs no special path. The magnitude algorithm yields q_mag=16'hFFFF and r_mag=|a|. The required result is quotient = `neg_q ? 16'h0001 : 16'hFFFF` and remainder = `a`, with the same latency.
- `start` is ignored while `busy`=1. `a` and `b` may change freely after the accepting edge.

## Timing
- Edge E0 samples `start` in IDLE. CALC occupies edges E0+1 … E0+16, and FIX is edge E0+17.
- `busy` is high after E0 through the cycle before `done`. It is low in the `done` cycle.
- `done` is high for exactly the one cycle following E0+17. Latency from start to done is 17 cycles.
- A `start` asserted in the `done` cycle is accepted, since the state is IDLE. Back-to-back throughput is one result per 18 cycles.
- `quotient`, `remainder` and `div_zero` change only at the FIX edge.
- Reset, including mid-operation:
  - state returns to IDLE immediately;
  - `busy`, `done`, `quotient`, `remainder` and `div_zero` all go to 0;
  - the interrupted operation produces no `done`.

## Configuration
- Macro `SEQ_DIV_ZERO_ERR_EN`.
- **Defined:** the `div_zero` output exists. It is registered at the FIX edge as (latched `b` == 0) and held until the next completion. It is 0 on reset. Quotient and remainder values are unchanged.
- **Undefined:** the port and its flop are absent, and divide-by-zero is silent with the results defined above.

## Structure
- Package `div_pkg`:
  - constant `DIV_W = 16` and `DIV_STEPS = DIV_W`;
  - state typedef enum `{IDLE, CALC, FIX}`;
  - counter width `$clog2(DIV_STEPS)`.
- Sub-module `div_step` (combinational): takes `rem`, the next dividend bit and `|b|`; returns the new `rem` and the quotient bit.
- The top level holds the FSM, counter, operand registers and sign fix.

## Test plan
- `a`=100, `b`=-5, `start` for 1 cycle → `busy` 1 for 17 cycles; `done` pulse exactly 17 cycles after the start edge; quotient -20, remainder 0.
- `a`=-15, `b`=4 → quotient -3, remainder -3. `a`=-25, `b`=-4 → quotient 6, remainder -1.
- `a`=32767, `b`=2 → 16383 r 1. `a`=-32768, `b`=-1 → -32768 r 0. `a`=0, `b`=1234 → 0 r 0.
- `a`=1234, `b`=0 → quotient -1, remainder 1234, `div_zero`=1 if enabled. `a`=-7, `b`=0 → quotient 1, remainder -7.
- Re-pulse `start` with new operands at cycle 5 of an operation → ignored, and the first result is unaffected. Pulse `start` in the `done` cycle → second operation completes 17 cycles later.
- Assert `rst` at cycle 8 of an operation → all outputs 0 immediately; no `done`; the next `start` works normally.
- Randomized: 2000 random pairs checked against Verilog `/` and `%`.

Source files
------------

// File: rtl/seq_div_16_pkg.sv
// Shared constants and FSM state type for the 16-bit sequential signed divider.
package div_pkg;
  localparam int DIV_W     = 16;
  localparam int DIV_STEPS = DIV_W;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;
endpackage

// File: rtl/seq_div_16_if.sv
// Start/busy/done handshake bundle for seq_div_16.
// The div_zero flag exists only when SEQ_DIV_ZERO_ERR_EN is defined.
interface seq_div_16_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
);
  logic                    start;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;
`ifdef SEQ_DIV_ZERO_ERR_EN
  logic                    div_zero;

  modport master (output start, a, b, input busy, done, quotient, remainder, div_zero);
  modport slave  (input start, a, b, output busy, done, quotient, remainder, div_zero);
`else
  modport master (output start, a, b, input busy, done, quotient, remainder);
  modport slave  (input start, a, b, output busy, done, quotient, remainder);
`endif
endinterface

// File: rtl/seq_div_16_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit and
// subtract the divisor when the result stays non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] bmag_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] divisor;

  // NOTE: every output is assigned on every path through always_comb, so no latch is inferred.
  always_comb begin
    shifted = {rem_i, bit_i};
    divisor = {2'b00, bmag_i};
    q_o     = (shifted >= divisor);
    rem_o   = (WIDTH+1)'(q_o ? (shifted - divisor) : shifted);
  end
endmodule

// File: rtl/seq_div_16.sv
// Sequential 16-bit signed divider: 16 restoring steps on magnitudes, then a sign fix.
// Optional divide-by-zero flag output enabled by SEQ_DIV_ZERO_ERR_EN.
module seq_div_16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  seq_div_16_if.slave  bus
);
  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH:0]    rem_q;
  logic [WIDTH-1:0]  dvd_q;
  logic [WIDTH-1:0]  bmag_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  remo_q;
`ifdef SEQ_DIV_ZERO_ERR_EN
  logic              div_zero_q;
`endif

  logic [WIDTH:0]    rem_d;
  logic              qbit_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH:0] m);
    return WIDTH'(neg ? (~m + {{WIDTH{1'b0}}, 1'b1}) : m);
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .bmag_i (bmag_q),
    .rem_o  (rem_d),
    .q_o    (qbit_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      bmag_q     <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      remo_q     <= '0;
`ifdef SEQ_DIV_ZERO_ERR_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            dvd_q   <= mag(bus.a);
            bmag_q  <= mag(bus.b);
            neg_q_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r_q <= bus.a[WIDTH-1];
            rem_q   <= '0;
            cnt_q   <= CNT_W'(DIV_STEPS - 1);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          // Quotient bits enter at the LSB as dividend bits leave the MSB.
          rem_q <= rem_d;
          dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          quot_q     <= apply_sign(neg_q_q, {1'b0, dvd_q});
          remo_q     <= apply_sign(neg_r_q, rem_q);
`ifdef SEQ_DIV_ZERO_ERR_EN
          div_zero_q <= (bmag_q == '0);
`endif
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = remo_q;
`ifdef SEQ_DIV_ZERO_ERR_EN
  assign bus.div_zero  = div_zero_q;
`endif
endmodule

// File: tb/tb_seq_div_16.sv
// Self-checking bench for seq_div_16: directed corner cases, handshake timing,
// mid-operation reset and randomized operands against a truncating-division model.
module tb_seq_div_16;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_div_16_if bus ();

  seq_div_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: plain integer truncating division; divide by zero per the defined result.
  function automatic void model(input logic signed [15:0] a, input logic signed [15:0] b,
                                output logic signed [15:0] q, output logic signed [15:0] r);
    int ai;
    int bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = (ai < 0) ? 16'sd1 : -16'sd1;
      r = a;
    end else begin
      q = 16'(ai / bi);
      r = 16'(ai % bi);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic launch(input logic signed [15:0] av, input logic signed [15:0] bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  // Called just after the accepting edge; returns edges until done and busy-high samples.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cycles++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) tick();
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags busy/done=%b required=00", {bus.busy, bus.done});
    end
    total++;
    if (bus.quotient !== 16'sd0 || bus.remainder !== 16'sd0) begin
      bad++;
      $display("FAIL reset_results q=%0d r=%0d required 0 0", bus.quotient, bus.remainder);
    end
`ifdef SEQ_DIV_ZERO_ERR_EN
    total++;
    if (bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_div_zero got=%b required=0", bus.div_zero);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic signed [15:0] ta [8];
    logic signed [15:0] tb [8];
    logic signed [15:0] tq [8];
    logic signed [15:0] tr [8];
    int lat;
    int bc;
    ta = '{16'sd100, -16'sd15, -16'sd25, 16'sd32767, 16'h8000, 16'sd0,    16'sd1234, -16'sd7};
    tb = '{-16'sd5,  16'sd4,   -16'sd4,  16'sd2,     -16'sd1,  16'sd1234, 16'sd0,    16'sd0};
    tq = '{-16'sd20, -16'sd3,  16'sd6,   16'sd16383, 16'h8000, 16'sd0,    -16'sd1,   16'sd1};
    tr = '{16'sd0,   -16'sd3,  -16'sd1,  16'sd1,     16'sd0,   16'sd0,    16'sd1234, -16'sd7};
    for (int i = 0; i < 8; i++) begin
      launch(ta[i], tb[i]);
      wait_done(lat, bc);
      total++;
      if (lat !== 17) begin
        bad++;
        $display("FAIL dir%0d_latency got=%0d required=17", i, lat);
      end
      total++;
      if (bc !== 17) begin
        bad++;
        $display("FAIL dir%0d_busy_cycles got=%0d required=17", i, bc);
      end
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_busy_in_done got=%b required=0", i, bus.busy);
      end
      total++;
      if (bus.quotient !== tq[i]) begin
        bad++;
        $display("FAIL dir%0d_quotient %0d/%0d got=%0d required=%0d", i, ta[i], tb[i], bus.quotient, tq[i]);
      end
      total++;
      if (bus.remainder !== tr[i]) begin
        bad++;
        $display("FAIL dir%0d_remainder %0d%%%0d got=%0d required=%0d", i, ta[i], tb[i], bus.remainder, tr[i]);
      end
`ifdef SEQ_DIV_ZERO_ERR_EN
      total++;
      if (bus.div_zero !== (tb[i] == 16'sd0)) begin
        bad++;
        $display("FAIL dir%0d_div_zero got=%b required=%b", i, bus.div_zero, tb[i] == 16'sd0);
      end
`endif
      tick();
      total++;
      if (bus.done !== 1'b0 || bus.quotient !== tq[i] || bus.remainder !== tr[i]) begin
        bad++;
        $display("FAIL dir%0d_pulse_hold done=%b q=%0d r=%0d required done=0 q=%0d r=%0d",
                 i, bus.done, bus.quotient, bus.remainder, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int bc;
    launch(16'sd300, 16'sd7);
    repeat (4) tick();
    bus.start = 1'b1;
    bus.a = -16'sd9;
    bus.b = 16'sd2;
    tick();
    bus.start = 1'b0;
    wait_done(lat, bc);
    total++;
    if (lat + 5 !== 17) begin
      bad++;
      $display("FAIL ignore_latency got=%0d required=17", lat + 5);
    end
    total++;
    if (bus.quotient !== 16'sd42 || bus.remainder !== 16'sd6) begin
      bad++;
      $display("FAIL ignore_result q=%0d r=%0d required q=42 r=6", bus.quotient, bus.remainder);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_no_restart busy=%b required=0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    launch(-16'sd1000, 16'sd33);
    wait_done(lat, bc);
    total++;
    if (bus.done !== 1'b1 || bus.quotient !== -16'sd30 || bus.remainder !== -16'sd10) begin
      bad++;
      $display("FAIL b2b_first done=%b q=%0d r=%0d required done=1 q=-30 r=-10",
               bus.done, bus.quotient, bus.remainder);
    end
    launch(16'sd5000, -16'sd3);
    wait_done(lat, bc);
    total++;
    if (lat !== 17) begin
      bad++;
      $display("FAIL b2b_latency got=%0d required=17", lat);
    end
    total++;
    if (bus.quotient !== -16'sd1666 || bus.remainder !== 16'sd2) begin
      bad++;
      $display("FAIL b2b_second q=%0d r=%0d required q=-1666 r=2", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int bc;
    bit seen_done;
    launch(16'sd12345, -16'sd67);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.quotient !== 16'sd0 || bus.remainder !== 16'sd0) begin
      bad++;
      $display("FAIL midreset_outputs busy=%b done=%b q=%0d r=%0d required all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
`ifdef SEQ_DIV_ZERO_ERR_EN
    total++;
    if (bus.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL midreset_div_zero got=%b required=0", bus.div_zero);
    end
`endif
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (25) begin
      tick();
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_spurious_done got=1 required=0");
    end
    launch(16'sd12345, -16'sd67);
    wait_done(lat, bc);
    total++;
    if (lat !== 17 || bus.quotient !== -16'sd184 || bus.remainder !== 16'sd17) begin
      bad++;
      $display("FAIL midreset_recover lat=%0d q=%0d r=%0d required lat=17 q=-184 r=17",
               lat, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_random();
    logic signed [15:0] av;
    logic signed [15:0] bv;
    logic signed [15:0] eq;
    logic signed [15:0] er;
    int lat;
    int bc;
    for (int i = 0; i < 2000; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      case (i % 16)
        0:  bv = 16'sd0;
        1:  bv = -16'sd1;
        2:  av = 16'h8000;
        3:  bv = 16'h8000;
        4, 5, 6: bv = 16'($urandom_range(0, 16)) - 16'sd8;
        default: ;
      endcase
      model(av, bv, eq, er);
      launch(av, bv);
      wait_done(lat, bc);
      total++;
      if (lat !== 17) begin
        bad++;
        $display("FAIL rand%0d_latency got=%0d required=17", i, lat);
      end
      total++;
      if (bus.quotient !== eq || bus.remainder !== er) begin
        bad++;
        $display("FAIL rand%0d_result %0d/%0d q=%0d r=%0d required q=%0d r=%0d",
                 i, av, bv, bus.quotient, bus.remainder, eq, er);
      end
`ifdef SEQ_DIV_ZERO_ERR_EN
      total++;
      if (bus.div_zero !== (bv == 16'sd0)) begin
        bad++;
        $display("FAIL rand%0d_div_zero got=%b required=%b", i, bus.div_zero, bv == 16'sd0);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
